// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
//   Buffered UART transmitter. A write enqueues one character into a circular
//   FIFO and a serialiser drains it, so the writer never waits on the line.
//   Frame format: start, DATA_BITS data (LSB first), optional parity, and
//   STOP_BITS stop bits. Each bit lasts DIV clock cycles.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | line high; pops the FIFO head as soon as the FIFO holds data
//   START | start bit (low)
//   DATA  | payload bits, shifted out LSB first
//   PAR   | parity bit (present only when PARITY != 0)
//   STOP  | stop bit(s) (high); chains into START if more data is queued
//
// Ports
//   clk      system clock
//   nrst     asynchronous active-low reset
//   wr_en    enqueue request
//   wr_data  character to send (bits above DATA_BITS-1 are ignored)
//   clr_ovf  clears the sticky overflow flag
//   tx       serial output, idle high
//   full     FIFO holds DEPTH entries
//   empty    FIFO holds no entries
//   count    number of queued entries (0..DEPTH)
//   busy     frame in progress or FIFO non-empty
//   overflow sticky; set by a write that was dropped because the FIFO was full
module uart_tx_buffered #(
    parameter int DEPTH     = 16,
    parameter int DIV       = 868,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   clr_ovf,
    output logic                   tx,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DIV);
    localparam logic [7:0] DATA_MASK = 8'((9'd1 << DATA_BITS) - 9'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t        state, state_n;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    head;
    logic          head_par;
    logic          par_bit, par_n;
    logic          tx_n;
    logic          pop;
    logic          wr_ok;
    logic          baud_done;

    assign head      = mem[rd_ptr] & DATA_MASK;
    assign head_par  = (PARITY == 2) ? ~(^head) : (^head);
    assign baud_done = (baud_cnt == BW'(DIV - 1));
    // A pop in the same cycle frees a slot, so a write into a full FIFO is
    // still accepted when the serialiser takes the head on that edge.
    assign wr_ok     = wr_en && (!full || pop);
    assign busy      = (state != S_IDLE) || !empty;

    // ---------------- FIFO ----------------
    always_comb begin
        count_n = count;
        if (wr_ok && !pop) begin
            count_n = count + 1'b1;
        end else if (!wr_ok && pop) begin
            count_n = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_n;
            full  <= (count_n == CW'(DEPTH));
            empty <= (count_n == '0);
            // set wins over clear
            if (wr_en && !wr_ok) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // ---------------- serialiser ----------------
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        shift_n = shift;
        par_n   = par_bit;
        bit_n   = bit_cnt;
        baud_n  = baud_done ? '0 : baud_cnt + 1'b1;
        case (state)
            S_IDLE: begin
                baud_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    par_n   = head_par;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    bit_n   = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    shift_n = shift >> 1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        bit_n   = '0;
                        state_n = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (baud_done) begin
                    bit_n   = '0;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    if (bit_cnt == 3'(STOP_BITS - 1)) begin
                        bit_n = '0;
                        if (!empty) begin
                            // chain straight into the next frame, no idle gap
                            pop     = 1'b1;
                            shift_n = head;
                            par_n   = head_par;
                            state_n = S_START;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // tx is registered from the next state so it changes on the same edge
    // as the state it belongs to.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = shift_n[0];
            S_PAR:   tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            par_bit  <= par_n;
            tx       <= tx_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       we_a = 1'b0, we_b = 1'b0, clr_a = 1'b0, clr_b = 1'b0;
    logic [7:0] wd = 8'h00;
    logic       tx_a, full_a, empty_a, busy_a, overflow_a;
    logic       tx_b, full_b, empty_b, busy_b, overflow_b;
    logic [2:0] count_a, count_b;

    always #5 clk = ~clk;

    uart_tx_buffered #(.DEPTH(DEPTH), .DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .nrst(nrst), .wr_en(we_a), .wr_data(wd), .clr_ovf(clr_a),
        .tx(tx_a), .full(full_a), .empty(empty_a), .count(count_a), .busy(busy_a), .overflow(overflow_a));

    uart_tx_buffered #(.DEPTH(DEPTH), .DIV(DIV), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut_b (
        .clk(clk), .nrst(nrst), .wr_en(we_b), .wr_data(wd), .clr_ovf(clr_b),
        .tx(tx_b), .full(full_b), .empty(empty_b), .count(count_b), .busy(busy_b), .overflow(overflow_b));

    // phase 0 exercises the 8N1 instance, phase 1 the 7O2 instance
    bit   phase = 1'b0;
    int   cfg_db = 8, cfg_par = 0, cfg_sb = 1;
    logic       cur_tx;
    logic [6:0] cur_stat;
    assign cur_tx   = phase ? tx_b : tx_a;
    assign cur_stat = phase ? {count_b, full_b, empty_b, busy_b, overflow_b}
                            : {count_a, full_a, empty_a, busy_a, overflow_a};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Reference model: each accepted character is in the FIFO from the edge
    // it was written until the edge its frame starts, and its frame starts
    // one edge after the write or as soon as the previous frame ends.
    typedef struct {
        int         wr;
        int         st;
        logic [7:0] d;
    } ent_t;
    ent_t mq[$];
    ent_t sbq[$];
    int   last_st = 0;
    bit   have_last = 1'b0;
    bit   m_ovf = 1'b0;

    function automatic int flen();
        return (1 + cfg_db + ((cfg_par != 0) ? 1 : 0) + cfg_sb) * DIV;
    endfunction

    function automatic logic frame_bit(input logic [7:0] d, input int b);
        logic p;
        if (b == 0) return 1'b0;
        if (b <= cfg_db) return d[b-1];
        if (cfg_par != 0 && b == cfg_db + 1) begin
            p = 1'b0;
            for (int k = 0; k < cfg_db; k++) p ^= d[k];
            return (cfg_par == 2) ? ~p : p;
        end
        return 1'b1;
    endfunction

    task automatic check_status();
        int c = cyc;
        int cnt = 0;
        bit inf = 1'b0;
        logic [6:0] exp;
        foreach (mq[i]) begin
            if (mq[i].wr <= c && c < mq[i].st) cnt++;
            if (mq[i].st <= c && c < mq[i].st + flen()) inf = 1'b1;
        end
        exp = {3'(cnt), cnt == DEPTH, cnt == 0, inf || cnt > 0, m_ovf};
        total++;
        if (cur_stat !== exp) begin
            bad++;
            $display("FAIL status cyc=%0d got {count,full,empty,busy,ovf}=%b want %b", c, cur_stat, exp);
        end
    endtask

    // Called at a negedge: checks the state after the last edge, then drives
    // the inputs sampled at the next edge and advances to the next negedge.
    task automatic step(input bit we, input logic [7:0] d, input bit clr);
        int   e_edge;
        int   pre = 0;
        bit   pop = 1'b0;
        bit   acc;
        ent_t n;
        check_status();
        e_edge = cyc + 1;
        foreach (mq[i]) begin
            if (mq[i].wr < e_edge && mq[i].st >= e_edge) pre++;
            if (mq[i].st == e_edge) pop = 1'b1;
        end
        acc = we && (pre < DEPTH || pop);
        if (acc) begin
            n.wr = e_edge;
            n.d  = d;
            n.st = e_edge + 1;
            if (have_last && last_st + flen() > n.st) n.st = last_st + flen();
            mq.push_back(n);
            sbq.push_back(n);
            last_st   = n.st;
            have_last = 1'b1;
        end
        if (we && !acc) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (phase) begin we_b = we; clr_b = clr; end
        else       begin we_a = we; clr_a = clr; end
        wd = d;
        @(negedge clk);
        while (mq.size() > 0 && mq[0].st + flen() < cyc) void'(mq.pop_front());
    endtask

    task automatic do_reset();
        #2 nrst = 1'b0;
        we_a = 1'b0; we_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        #1;
        total++;
        if ({cur_tx, cur_stat} !== 8'b1_000_0100) begin
            bad++;
            $display("FAIL async_reset got {tx,count,full,empty,busy,ovf}=%b want 10000100", {cur_tx, cur_stat});
        end
        mq.delete();
        sbq.delete();
        have_last = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        #2 nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || mq.size() != 0) && n < 2000) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        repeat (4) step(1'b0, 8'h00, 1'b0);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout frames still pending=%0d want 0", sbq.size());
        end
    endtask

    task automatic rand_run(input int nsteps);
        int pct = 20;
        for (int i = 0; i < nsteps; i++) begin
            if (i % 50 == 0) begin
                case ($urandom_range(0, 3))
                    0:       pct = 60;
                    1:       pct = 15;
                    2:       pct = 3;
                    default: pct = 90;
                endcase
            end
            step($urandom_range(0, 99) < pct, 8'($urandom), $urandom_range(0, 99) < 4);
        end
    endtask

    // Monitor: decodes frames from the line and compares them with the
    // scoreboard, cycle by cycle, including the start time.
    initial begin : monitor
        ent_t e;
        int   s, n, errs, first;
        bit   ab;
        forever begin
            @(negedge clk);
            if (nrst && cur_tx === 1'b0) begin
                s = cyc;
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL start_unexpected cyc=%0d got tx=0 want idle line", s);
                end else begin
                    e = sbq.pop_front();
                    total++;
                    if (s != e.st) begin
                        bad++;
                        $display("FAIL start_time data=%h got cyc=%0d want cyc=%0d", e.d, s, e.st);
                    end
                    n = flen();
                    errs = 0;
                    first = -1;
                    ab = 1'b0;
                    for (int i = 0; i < n; i++) begin
                        if (i > 0) @(negedge clk);
                        if (!nrst) begin ab = 1'b1; break; end
                        if (cur_tx !== frame_bit(e.d, i / DIV)) begin
                            errs++;
                            if (first < 0) first = i;
                        end
                    end
                    if (!ab) begin
                        total++;
                        if (errs != 0) begin
                            bad++;
                            $display("FAIL frame data=%h got %0d wrong tx cycles (first at offset %0d) want 0", e.d, errs, first);
                        end
                    end
                end
            end
        end
    end

    initial begin : main
        int e0;
        int s;
        repeat (3) @(negedge clk);
        total++;
        if ({tx_a, count_a, full_a, empty_a, busy_a, overflow_a,
             tx_b, count_b, full_b, empty_b, busy_b, overflow_b} !== 16'b1_000_0100_1_000_0100) begin
            bad++;
            $display("FAIL reset_values got %b want 1000010010000100",
                     {tx_a, count_a, full_a, empty_a, busy_a, overflow_a,
                      tx_b, count_b, full_b, empty_b, busy_b, overflow_b});
        end
        #2 nrst = 1'b1;
        @(negedge clk);

        // idle after reset
        repeat (100) step(1'b0, 8'h00, 1'b0);

        // single 8N1 frame
        step(1'b1, 8'h55, 1'b0);
        drain();

        // fill: five accepted, sixth dropped
        e0 = cyc + 1;
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b0);
        total++;
        if ({count_a, full_a, overflow_a} !== 5'b100_1_1) begin
            bad++;
            $display("FAIL fill got {count,full,ovf}=%b want 10011", {count_a, full_a, overflow_a});
        end
        step(1'b0, 8'h00, 1'b1);
        // write on the exact edge the next frame is popped
        while (cyc + 1 != e0 + 1 + flen()) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hA5, 1'b0);
        total++;
        if ({count_a, overflow_a} !== 4'b100_0) begin
            bad++;
            $display("FAIL pop_write_full got {count,ovf}=%b want 1000", {count_a, overflow_a});
        end
        drain();

        // reset during data bit 3 of a frame, with overflow set
        e0 = cyc + 1;
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        s = e0 + 1;
        while (cyc != s + 4 * DIV + 1) step(1'b0, 8'h00, 1'b0);
        do_reset();
        step(1'b1, 8'hC3, 1'b0);
        drain();

        rand_run(1500);
        drain();

        // 7 data bits, odd parity, 2 stop bits
        do_reset();
        phase = 1'b1;
        cfg_db = 7; cfg_par = 2; cfg_sb = 2;
        step(1'b1, 8'h03, 1'b0);
        drain();
        rand_run(800);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
